// File: rtl/dmem_uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_uart_pkg
// Description : Shared address map, STATUS bit layout and TX FSM state type
//               for the data-memory / UART responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_uart_pkg;

    localparam logic [31:0] TXDATA_ADDR = 32'h0000_1000;
    localparam logic [31:0] STATUS_ADDR = 32'h0000_1004;

    localparam int ST_BUSY      = 0;
    localparam int ST_FULL      = 1;
    localparam int ST_EMPTY     = 2;
    localparam int ST_OVERFLOW  = 3;
    localparam int ST_COUNT_LSB = 4;
    localparam int ST_COUNT_W   = 5;
    localparam int ST_PARITY    = 9;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_t;

endpackage
`default_nettype wire

// File: rtl/uart_tx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_tx_fifo
// Description : Synchronous FIFO; a push while full is accepted only when a
//               pop happens in the same cycle, otherwise it is dropped.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_tx_fifo #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       i_push,
    input  logic [WIDTH-1:0]           i_wdata,
    input  logic                       i_pop,
    output logic [WIDTH-1:0]           o_rdata,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [$clog2(DEPTH+1)-1:0] o_count,
    output logic                       o_drop
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_do_push;
    logic             w_do_pop;

    assign o_full    = (r_count == CW'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_count   = r_count;
    assign o_rdata   = r_mem[r_rd_ptr];
    assign w_do_pop  = i_pop && !o_empty;
    assign w_do_push = i_push && (!o_full || w_do_pop);
    assign o_drop    = i_push && !w_do_push;

    always_ff @(posedge clk) begin
        if (w_do_push) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are log2(DEPTH) wide, so they wrap modulo DEPTH on their own.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_do_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            if (w_do_push && !w_do_pop) begin
                r_count <= r_count + CW'(1);
            end else if (w_do_pop && !w_do_push) begin
                r_count <= r_count - CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_uart_responder
// Description : Data-bus responder with data RAM and FIFO-fed UART TX.
//               Define UART_PARITY_EN for 8E1 frames (default 8N1).
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_uart_responder
    import dmem_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int FIFO_DEPTH   = 8,
    parameter int RAM_WORDS    = 64
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        MemWrite_i,
    input  logic [31:0] Addr_i,
    input  logic [31:0] WriteData_i,
    output logic [31:0] ReadData_o,
    output logic        tx_o
);

    localparam int RAM_AW = (RAM_WORDS > 1) ? $clog2(RAM_WORDS) : 1;
    localparam int BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] c_baud_last = BAUD_W'(CLKS_PER_BIT - 1);
`ifdef UART_PARITY_EN
    localparam logic c_parity_en = 1'b1;
`else
    localparam logic c_parity_en = 1'b0;
`endif

    logic [31:0]       r_ram [RAM_WORDS];
    tx_state_t         r_state;
    tx_state_t         w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic              r_tx;
    logic              w_tx_next;
    logic              r_overflow;
    logic              w_baud_done;
    logic              w_pop;

    logic              w_sel_ram;
    logic              w_sel_txdata;
    logic              w_sel_status;
    logic [RAM_AW-1:0] w_ram_idx;
    logic              w_push;
    logic [7:0]        w_fifo_rdata;
    logic              w_fifo_full;
    logic              w_fifo_empty;
    logic [CNT_W-1:0]  w_fifo_count;
    logic              w_fifo_drop;
    logic [31:0]       w_status;

    assign w_sel_ram    = (Addr_i < 32'(4 * RAM_WORDS));
    assign w_sel_txdata = (Addr_i[31:2] == TXDATA_ADDR[31:2]);
    assign w_sel_status = (Addr_i[31:2] == STATUS_ADDR[31:2]);
    assign w_ram_idx    = Addr_i[RAM_AW+1:2];
    assign w_push       = MemWrite_i && w_sel_txdata && !reset_i;

    always_ff @(posedge clk_i) begin
        if (MemWrite_i && w_sel_ram) begin
            r_ram[w_ram_idx] <= WriteData_i;
        end
    end

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (8)
    ) u_fifo (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_push  (w_push),
        .i_wdata (WriteData_i[7:0]),
        .i_pop   (w_pop),
        .o_rdata (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_count (w_fifo_count),
        .o_drop  (w_fifo_drop)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_overflow <= 1'b0;
        end else if (MemWrite_i && w_sel_status) begin
            r_overflow <= 1'b0;
        end else if (w_fifo_drop) begin
            r_overflow <= 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_tx    <= w_tx_next;
            if (w_pop) begin
                r_shift <= w_fifo_rdata;
            end
        end
    end

    assign w_baud_done = (r_baud == c_baud_last);

    always_comb begin
        w_state_next = r_state;
        w_bit_next   = r_bit;
        w_pop        = 1'b0;
        w_baud_next  = w_baud_done ? '0 : r_baud + BAUD_W'(1);
        case (r_state)
            IDLE: begin
                w_baud_next = '0;
                if (!w_fifo_empty) begin
                    w_pop        = 1'b1;
                    w_state_next = START;
                end
            end
            START: begin
                if (w_baud_done) begin
                    w_state_next = DATA;
                    w_bit_next   = '0;
                end
            end
            DATA: begin
                if (w_baud_done) begin
                    if (r_bit == 3'd7) begin
                        w_bit_next   = '0;
                        w_state_next = c_parity_en ? PARITY : STOP;
                    end else begin
                        w_bit_next = r_bit + 3'd1;
                    end
                end
            end
            PARITY: begin
                if (w_baud_done) begin
                    w_state_next = STOP;
                end
            end
            STOP: begin
                if (w_baud_done) begin
                    // Chain straight into the next frame to avoid an idle gap.
                    if (!w_fifo_empty) begin
                        w_pop        = 1'b1;
                        w_state_next = START;
                    end else begin
                        w_state_next = IDLE;
                    end
                end
            end
            default: begin
                w_state_next = IDLE;
                w_baud_next  = '0;
                w_bit_next   = '0;
            end
        endcase
    end

    // Line level is computed for the upcoming state so r_tx is aligned with it.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            START:   w_tx_next = 1'b0;
            DATA:    w_tx_next = r_shift[w_bit_next];
            PARITY:  w_tx_next = ^r_shift;
            default: w_tx_next = 1'b1;
        endcase
    end

    assign tx_o = r_tx;

    always_comb begin
        w_status                                   = '0;
        w_status[ST_BUSY]                          = (r_state != IDLE);
        w_status[ST_FULL]                          = w_fifo_full;
        w_status[ST_EMPTY]                         = w_fifo_empty;
        w_status[ST_OVERFLOW]                      = r_overflow;
        w_status[ST_COUNT_LSB +: ST_COUNT_W]       = ST_COUNT_W'(w_fifo_count);
        w_status[ST_PARITY]                        = c_parity_en;
    end

    always_comb begin
        ReadData_o = '0;
        if (w_sel_ram) begin
            ReadData_o = r_ram[w_ram_idx];
        end else if (w_sel_status) begin
            ReadData_o = w_status;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_uart_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_uart_responder
// Description : Self-checking bench for dmem_uart_responder against a
//               frame-level reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_uart_responder;
    import dmem_uart_pkg::*;

    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int RW    = 64;
`ifdef UART_PARITY_EN
    localparam int FBITS = 11;
    localparam bit PAR   = 1'b1;
`else
    localparam int FBITS = 10;
    localparam bit PAR   = 1'b0;
`endif
    localparam int FRAME = FBITS * CPB;

    logic        clk;
    logic        reset_i;
    logic        MemWrite_i;
    logic [31:0] Addr_i;
    logic [31:0] WriteData_i;
    logic [31:0] ReadData_o;
    logic        tx_o;

    int n_cmp = 0;
    int n_bad = 0;

    dmem_uart_responder #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (DEPTH),
        .RAM_WORDS    (RW)
    ) dut (
        .clk_i       (clk),
        .reset_i     (reset_i),
        .MemWrite_i  (MemWrite_i),
        .Addr_i      (Addr_i),
        .WriteData_i (WriteData_i),
        .ReadData_o  (ReadData_o),
        .tx_o        (tx_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Reference model: bytes waiting, cycles left in the frame on the wire.
    logic [7:0]  m_fifo[$];
    logic [7:0]  m_cur = 8'h00;
    int          m_rem = 0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_ram [RW];

    function automatic logic exp_tx();
        int b;
        if (m_rem == 0) return 1'b1;
        b = (FRAME - m_rem) / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        if (PAR && b == 9) return ^m_cur;
        return 1'b1;
    endfunction

    function automatic logic [31:0] exp_status();
        logic [31:0] s;
        s      = '0;
        s[0]   = (m_rem != 0);
        s[1]   = (m_fifo.size() == DEPTH);
        s[2]   = (m_fifo.size() == 0);
        s[3]   = m_ovf;
        s[8:4] = 5'(m_fifo.size());
        s[9]   = PAR;
        return s;
    endfunction

    function automatic logic [31:0] exp_read(input logic [31:0] a);
        if (a < 32'(4 * RW)) return m_ram[a[7:2]];
        if (a[31:2] == 30'h401) return exp_status();
        return 32'h0;
    endfunction

    task automatic model_step();
        if (MemWrite_i && Addr_i < 32'(4 * RW)) m_ram[Addr_i[7:2]] = WriteData_i;
        if (reset_i) begin
            m_fifo.delete();
            m_rem = 0;
            m_ovf = 1'b0;
            return;
        end
        if (m_fifo.size() > 0 && m_rem <= 1) begin
            m_cur = m_fifo.pop_front();
            m_rem = FRAME;
        end else if (m_rem > 0) begin
            m_rem = m_rem - 1;
        end
        if (MemWrite_i && Addr_i[31:2] == 30'h400) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(WriteData_i[7:0]);
            else m_ovf = 1'b1;
        end
        if (MemWrite_i && Addr_i[31:2] == 30'h401) m_ovf = 1'b0;
    endtask

    task automatic drive(input logic we, input logic [31:0] a, input logic [31:0] d);
        MemWrite_i  = we;
        Addr_i      = a;
        WriteData_i = d;
        #1;
    endtask

    task automatic step();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_i = 1'b1;
        drive(1'b0, STATUS_ADDR, 32'h0);
        step();
        step();
        n_cmp++;
        if (tx_o !== 1'b1) begin
            n_bad++; $display("FAIL reset_tx got=%b exp=1", tx_o);
        end
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o !== (32'h4 | (32'(PAR) << 9))) begin
            n_bad++; $display("FAIL reset_status got=%h exp=%h", ReadData_o, 32'h4 | (32'(PAR) << 9));
        end
        reset_i = 1'b0;
    endtask

    task automatic test_ram();
        for (int i = 0; i < RW; i++) begin
            drive(1'b1, 32'(i * 4), $urandom);
            step();
        end
        drive(1'b1, 32'h8, 32'hDEAD_BEEF);
        step();
        drive(1'b0, 32'h8, 32'h0);
        n_cmp++;
        if (ReadData_o !== 32'hDEAD_BEEF) begin
            n_bad++; $display("FAIL ram_word2 got=%h exp=deadbeef", ReadData_o);
        end
        drive(1'b0, 32'h2000, 32'h0);
        n_cmp++;
        if (ReadData_o !== 32'h0) begin
            n_bad++; $display("FAIL unmapped_read got=%h exp=0", ReadData_o);
        end
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 32'($urandom_range(0, 4 * RW - 1)), 32'h0);
            n_cmp++;
            if (ReadData_o !== exp_read(Addr_i)) begin
                n_bad++; $display("FAIL ram_read a=%h got=%h exp=%h", Addr_i, ReadData_o, exp_read(Addr_i));
            end
        end
    endtask

    task automatic test_drain();
        int guard = 0;
        while ((m_rem != 0 || m_fifo.size() != 0) && guard < 8 * FRAME) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            n_cmp++;
            if (ReadData_o !== exp_status()) begin
                n_bad++; $display("FAIL drain_status got=%h exp=%h", ReadData_o, exp_status());
            end
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL drain_tx got=%b exp=%b", tx_o, exp_tx());
            end
            guard++;
        end
        n_cmp++;
        if (guard >= 8 * FRAME) begin
            n_bad++; $display("FAIL drain_budget got=%0d exp<%0d", guard, 8 * FRAME);
        end
    endtask

    task automatic test_single_byte();
        drive(1'b1, TXDATA_ADDR, 32'h55);
        step();
        for (int i = 0; i < FRAME + 4; i++) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            n_cmp++;
            if (ReadData_o !== exp_status()) begin
                n_bad++; $display("FAIL single_status cyc=%0d got=%h exp=%h", i, ReadData_o, exp_status());
            end
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL single_tx cyc=%0d got=%b exp=%b", i, tx_o, exp_tx());
            end
        end
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o[0] !== 1'b0 || ReadData_o[2] !== 1'b1) begin
            n_bad++; $display("FAIL single_done busy/empty got=%b/%b exp=0/1", ReadData_o[0], ReadData_o[2]);
        end
    endtask

    task automatic test_back_to_back();
        int busy = 0;
        drive(1'b1, TXDATA_ADDR, 32'hA5);
        step();
        drive(1'b1, TXDATA_ADDR, 32'h3C);
        step();
        for (int i = 0; i < 2 * FRAME + 6; i++) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            if (ReadData_o[0] === 1'b1) busy++;
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL b2b_tx cyc=%0d got=%b exp=%b", i, tx_o, exp_tx());
            end
        end
        n_cmp++;
        if (busy != 2 * FRAME) begin
            n_bad++; $display("FAIL b2b_busy_cycles got=%0d exp=%0d", busy, 2 * FRAME);
        end
    endtask

    task automatic test_overflow();
        drive(1'b1, TXDATA_ADDR, 32'h11);
        step();
        drive(1'b0, STATUS_ADDR, 32'h0);
        step();
        for (int i = 0; i < 5; i++) begin
            drive(1'b1, TXDATA_ADDR, 32'($urandom_range(0, 255)));
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL ovf_tx got=%b exp=%b", tx_o, exp_tx());
            end
        end
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o !== exp_status() || ReadData_o[3] !== 1'b1 || ReadData_o[8:4] !== 5'd4
            || ReadData_o[1] !== 1'b1) begin
            n_bad++; $display("FAIL ovf_status got=%h exp=%h", ReadData_o, exp_status());
        end
        drive(1'b1, STATUS_ADDR, 32'h0);
        step();
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o[3] !== 1'b0 || ReadData_o !== exp_status()) begin
            n_bad++; $display("FAIL ovf_clear got=%h exp=%h", ReadData_o, exp_status());
        end
        test_drain();
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        drive(1'b1, TXDATA_ADDR, 32'hC3);
        step();
        while (!(m_rem != 0 && FRAME - m_rem == 4 * CPB) && guard < 2 * FRAME) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL midrst_pre_tx got=%b exp=%b", tx_o, exp_tx());
            end
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_bad++; $display("FAIL midrst_reach_bit3 got=%0d exp<%0d", guard, 2 * FRAME);
        end
        reset_i = 1'b1;
        drive(1'b0, STATUS_ADDR, 32'h0);
        step();
        reset_i = 1'b0;
        n_cmp++;
        if (tx_o !== 1'b1) begin
            n_bad++; $display("FAIL midrst_tx got=%b exp=1", tx_o);
        end
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o !== (32'h4 | (32'(PAR) << 9))) begin
            n_bad++; $display("FAIL midrst_status got=%h exp=%h", ReadData_o, 32'h4 | (32'(PAR) << 9));
        end
        for (int i = 0; i < FRAME; i++) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            step();
            n_cmp++;
            if (tx_o !== 1'b1) begin
                n_bad++; $display("FAIL midrst_resumed cyc=%0d got=%b exp=1", i, tx_o);
            end
        end
    endtask

    task automatic test_push_full_pop();
        int guard = 0;
        drive(1'b1, TXDATA_ADDR, 32'h81);
        step();
        drive(1'b0, STATUS_ADDR, 32'h0);
        step();
        for (int i = 0; i < DEPTH; i++) begin
            drive(1'b1, TXDATA_ADDR, 32'(8'h40 + i));
            step();
        end
        while (m_rem != 1 && guard < 2 * FRAME) begin
            drive(1'b0, STATUS_ADDR, 32'h0);
            step();
            guard++;
        end
        n_cmp++;
        if (guard >= 2 * FRAME) begin
            n_bad++; $display("FAIL pfp_reach_stop got=%0d exp<%0d", guard, 2 * FRAME);
        end
        drive(1'b1, TXDATA_ADDR, 32'h99);
        step();
        drive(1'b0, STATUS_ADDR, 32'h0);
        n_cmp++;
        if (ReadData_o[8:4] !== 5'd4 || ReadData_o[3] !== 1'b0 || ReadData_o !== exp_status()) begin
            n_bad++; $display("FAIL pfp_status got=%h exp=%h", ReadData_o, exp_status());
        end
        test_drain();
    endtask

    task automatic test_random();
        int op;
        logic [31:0] a;
        for (int i = 0; i < 600; i++) begin
            op = $urandom_range(0, 9);
            case (op)
                0:       drive(1'b1, TXDATA_ADDR, $urandom);
                1:       drive(1'b1, STATUS_ADDR, $urandom);
                2, 3:    drive(1'b1, 32'($urandom_range(0, 4 * RW - 1)), $urandom);
                4, 5:    drive(1'b0, 32'($urandom_range(0, 4 * RW - 1)), 32'h0);
                6:       begin a = 32'h2000 + 32'($urandom_range(0, 4095)); drive(1'b1, a, $urandom); end
                default: drive(1'b0, STATUS_ADDR, 32'h0);
            endcase
            n_cmp++;
            if (ReadData_o !== exp_read(Addr_i)) begin
                n_bad++; $display("FAIL rand_read cyc=%0d a=%h got=%h exp=%h", i, Addr_i, ReadData_o, exp_read(Addr_i));
            end
            step();
            n_cmp++;
            if (tx_o !== exp_tx()) begin
                n_bad++; $display("FAIL rand_tx cyc=%0d got=%b exp=%b", i, tx_o, exp_tx());
            end
        end
        test_drain();
    endtask

    initial begin
        reset_i     = 1'b1;
        MemWrite_i  = 1'b0;
        Addr_i      = 32'h0;
        WriteData_i = 32'h0;
        @(negedge clk);
        test_reset();
        test_ram();
        test_single_byte();
        test_back_to_back();
        test_overflow();
        test_reset_midframe();
        test_push_full_pop();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/dmem_uart_responder.md
# dmem_uart_responder

Memory-mapped data-bus responder for the single-cycle RISC-V core: it sits on the far side of the core's data port, taking the ALU result as address and the store data as write data, and returning read data in the same cycle. It contains the data RAM and a UART transmitter with a transmit FIFO, so software sends bytes over the serial link with ordinary `sw`/`lw` instructions.

## Interface
- CLKS_PER_BIT, 434: clock cycles per UART bit (50 MHz / 115200); must be ≥2.
- FIFO_DEPTH, 8: TX FIFO entries; power of two, ≥2, ≤16.
- RAM_WORDS, 64: 32-bit words of data RAM.
- clk_i  in  1  single system clock, rising edge.
- reset_i  in  1  synchronous, active-high reset.
- MemWrite_i  in  1  store strobe from the control unit.
- Addr_i  in  32  byte address (core ALU result).
- WriteData_i  in  32  store data.
- ReadData_o  out  32  load data; combinational from Addr_i.
- tx_o  out  1  UART serial output, idle high.

## Operation
- Address map; Addr_i[1:0] ignored.
  - 0x0000_0000 to 4·RAM_WORDS−1: RAM. Read is combinational. Write takes effect at the clock edge when MemWrite_i=1.
  - 0x0000_1000 TXDATA: a write pushes WriteData_i[7:0]. Reads return 0.
  - 0x0000_1004 STATUS (read):
    - bit0 busy: FSM not IDLE.
    - bit1 full.
    - bit2 empty.
    - bit3 overflow (sticky).
    - bits[8:4] FIFO count.
    - All other bits 0.
  - Any write to STATUS clears overflow.
  - Unmapped addresses: reads return 0, writes are ignored.
- Reads have no side effects.
- Push to a full FIFO: the byte is dropped and overflow is set. Exception: if a pop happens in the same cycle, the push is accepted and count is unchanged.
- TX FSM states:
  - IDLE: tx_o=1. If the FIFO is non-empty, pop the head into the shift register, go to START.
  - START: tx_o=0 for CLKS_PER_BIT cycles, then DATA.
  - DATA: 8 bits, LSB first, each CLKS_PER_BIT cycles. Then PARITY if enabled, else STOP.
  - PARITY: see Configuration.
  - STOP: tx_o=1 for CLKS_PER_BIT cycles. Then START directly if the FIFO is non-empty (with pop), else IDLE. No extra idle cycles between back-to-back frames.
- Counters:
  - Baud counter 0..CLKS_PER_BIT−1 resets on each state/bit change.
  - Bit index 0..7.
- tx_o is driven from a register (glitch-free).

## Timing
- Store to TXDATA at edge N: FIFO count updates at N.
- FSM leaves IDLE at N+1; tx_o falls after edge N+1 (first start-bit cycle).
- Frame length: 10·CLKS_PER_BIT cycles, or 11·CLKS_PER_BIT with parity.
- RAM/STATUS reads: zero latency, same cycle as Addr_i.
- Values visible to a load are the pre-edge state of the cycle in which the load executes.
- Reset, including mid-frame, takes effect at the next edge:
  - FSM to IDLE; tx_o=1.
  - FIFO emptied: count=0, empty=1, full=0.
  - overflow=0; counters=0.
  - RAM contents are not reset.
  - The aborted frame is not resumed.
- Reset has priority over a simultaneous store.
- FIFO pointers wrap modulo FIFO_DEPTH. Count saturates at FIFO_DEPTH (full), never wraps.

## Configuration
- UART_PARITY_EN defined:
  - PARITY state inserted after DATA.
  - tx_o carries even parity (XOR of the 8 data bits) for CLKS_PER_BIT cycles.
  - STATUS bit9 reads 1.
- Undefined: no PARITY state, 8N1 frames, STATUS bit9 reads 0.

## Structure
- Shared package `dmem_uart_pkg`:
  - Address constants TXDATA_ADDR and STATUS_ADDR.
  - STATUS bit-position constants.
  - tx_state_t enum {IDLE, START, DATA, PARITY, STOP}.
- One sub-module, `uart_tx_fifo`: synchronous FIFO with push/pop, full/empty, count, and same-cycle push-on-full-with-pop rule.
- FSM, baud counter, RAM and address decode live in the top.

## Test plan
- Bench parameters: CLKS_PER_BIT=4, FIFO_DEPTH=4.
- RAM: store 0xDEADBEEF to 0x0000_0008, then load 0x0000_0008 → 0xDEADBEEF. Load 0x0000_2000 → 0x0000_0000.
- Single byte: store 0x55 to TXDATA at edge N.
  - tx_o low from N+1 for 4 cycles, then bits 1,0,1,0,1,0,1,0 at 4 cycles each, then stop high.
  - STATUS busy=1 during the frame; busy=0 and empty=1 after 40 cycles (44 with UART_PARITY_EN, parity bit=0).
- Back-to-back: store 0xA5 and 0x3C on consecutive cycles → two contiguous frames with no idle gap; total 80 cycles of activity.
- Overflow: with a frame in progress, store 5 bytes. The first 4 are accepted (full=1, count=4), the 5th is dropped and overflow=1. Store to STATUS → overflow=0.
- Reset mid-frame: assert reset_i during DATA bit 3 → next edge tx_o=1, STATUS=0x0000_0004, and the frame is not resumed after release.
- Push on full with pop: fill the FIFO while the FSM is in the last STOP cycle, store a byte → byte accepted, count stays 4, overflow stays 0.
